myproject_gauss_moments: RTL and testbench

// - Gaussian-spot parameter estimator for one cropped 48x48 single-channel image (post-crop stage).
// - Streams in pixels, then emits 5 parameters on 5 independent AXI-Stream outputs:

---
 rtl/myproject_gauss_moments.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_myproject_gauss_moments.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_gauss_moments.sv
// Gaussian-spot moment estimator for one cropped single-channel frame.
// Accumulates weighted pixel moments while streaming, divides them by the
// total weight with one shared restoring divider, then presents peak,
// centroid and variance on five independent AXI-Stream outputs.
//
// Handshake rule (all streams): a word transfers on a rising edge where
// TVALID and TREADY are both high; a producer holds TDATA stable and keeps
// TVALID high until that edge, and never waits for TREADY before raising TVALID.
module myproject_gauss_moments #(
    parameter int DATA_W   = 16,
    parameter int IMG_ROWS = 48,
    parameter int IMG_COLS = 48,
    parameter int ACC_W    = 40
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    input  logic [DATA_W-1:0] conv2d_input_V_data_0_V_TDATA,
    input  logic              conv2d_input_V_data_0_V_TVALID,
    output logic              conv2d_input_V_data_0_V_TREADY,
    output logic [DATA_W-1:0] layer15_out_V_data_0_V_TDATA,
    output logic              layer15_out_V_data_0_V_TVALID,
    input  logic              layer15_out_V_data_0_V_TREADY,
    output logic [DATA_W-1:0] layer15_out_V_data_1_V_TDATA,
    output logic              layer15_out_V_data_1_V_TVALID,
    input  logic              layer15_out_V_data_1_V_TREADY,
    output logic [DATA_W-1:0] layer15_out_V_data_2_V_TDATA,
    output logic              layer15_out_V_data_2_V_TVALID,
    input  logic              layer15_out_V_data_2_V_TREADY,
    output logic [DATA_W-1:0] layer15_out_V_data_3_V_TDATA,
    output logic              layer15_out_V_data_3_V_TVALID,
    input  logic              layer15_out_V_data_3_V_TREADY,
    output logic [DATA_W-1:0] layer15_out_V_data_4_V_TDATA,
    output logic              layer15_out_V_data_4_V_TVALID,
    input  logic              layer15_out_V_data_4_V_TREADY,
    output logic [1:0]        dbg_state
);

    localparam int ROW_W  = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int COL_W  = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam int CNT_W  = $clog2(ACC_W);
    localparam int PROD_W = 2 * ACC_W;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);
    localparam logic signed [DATA_W-1:0] PK_INIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t state, state_next;

    // accumulation datapath
    logic [ROW_W-1:0]         row;
    logic [COL_W-1:0]         col;
    logic [ACC_W-1:0]         s0, sx, sy, sxx, syy;
    logic signed [DATA_W-1:0] pk;
    logic signed [DATA_W-1:0] pix_s;
    logic [ACC_W-1:0]         w, c_ext, r_ext, w_c, w_r, w_cc, w_rr;
    logic                     in_beat, last_beat;

    // divider
    logic [1:0]       div_idx;
    logic [CNT_W-1:0] div_cnt;
    logic             div_busy, div_fin;
    logic [ACC_W:0]   div_rem, rem_shift, rem_next;
    logic [ACC_W-1:0] div_q, num_sel, q_next;
    logic             q_bit;
    logic [ACC_W-1:0] quot [4];

    // result formation and output streams
    logic [PROD_W-1:0] mx_w, my_w, qx_w, qy_w, mx_sq, my_sq, vx, vy;
    logic [DATA_W-1:0] res_data [5];
    logic [4:0]        res_valid, res_ready, res_hs;
    logic              res_clear;

    function automatic logic [DATA_W-1:0] sat_pos(input logic [PROD_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    assign pix_s     = signed'(conv2d_input_V_data_0_V_TDATA);
    assign w         = pix_s[DATA_W-1] ? '0 : ACC_W'(conv2d_input_V_data_0_V_TDATA);
    assign c_ext     = ACC_W'(col);
    assign r_ext     = ACC_W'(row);
    assign w_c       = w * c_ext;
    assign w_r       = w * r_ext;
    assign w_cc      = w_c * c_ext;
    assign w_rr      = w_r * r_ext;
    assign in_beat   = (state == S_ACCUM) && conv2d_input_V_data_0_V_TVALID;
    assign last_beat = in_beat && (row == ROW_LAST) && (col == COL_LAST);

    assign res_ready = {layer15_out_V_data_4_V_TREADY, layer15_out_V_data_3_V_TREADY,
                        layer15_out_V_data_2_V_TREADY, layer15_out_V_data_1_V_TREADY,
                        layer15_out_V_data_0_V_TREADY};
    assign res_hs    = res_valid & res_ready;
    assign res_clear = ((res_valid & ~res_hs) == 5'd0);
    assign dbg_state = state;

    // state register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_next;
    end

    // next-state and control outputs
    always_comb begin
        state_next                     = state;
        ap_idle                        = 1'b0;
        ap_done                        = 1'b0;
        conv2d_input_V_data_0_V_TREADY = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_next = S_ACCUM;
            end
            S_ACCUM: begin
                conv2d_input_V_data_0_V_TREADY = 1'b1;
                if (last_beat) state_next = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (div_fin) state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                // the last outstanding word is taken on this edge
                if (res_clear) begin
                    ap_done    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // moment accumulation, pixel position tracking and signed peak
    always_ff @(posedge ap_clk) begin
        if (ap_rst || (state == S_IDLE && ap_start)) begin
            row <= '0;
            col <= '0;
            s0  <= '0;
            sx  <= '0;
            sy  <= '0;
            sxx <= '0;
            syy <= '0;
            pk  <= ap_rst ? '0 : PK_INIT;
        end else if (in_beat) begin
            s0  <= s0 + w;
            sx  <= sx + w_c;
            sy  <= sy + w_r;
            sxx <= sxx + w_cc;
            syy <= syy + w_rr;
            if (pix_s > pk) pk <= pix_s;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ap_ready marks the cycle after the final pixel was accepted
    always_ff @(posedge ap_clk) begin
        if (ap_rst) ap_ready <= 1'b0;
        else        ap_ready <= last_beat;
    end

    // dividend selection for the current divide: Sx, Sy, Sxx, Syy in turn
    always_comb begin
        num_sel = sx;
        case (div_idx)
            2'd0: num_sel = sx;
            2'd1: num_sel = sy;
            2'd2: num_sel = sxx;
            2'd3: num_sel = syy;
            default: num_sel = sx;
        endcase
    end

    // one restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_shift = {div_rem[ACC_W-1:0], div_q[ACC_W-1]};
    assign q_bit     = (rem_shift >= {1'b0, s0});
    assign rem_next  = q_bit ? (rem_shift - {1'b0, s0}) : rem_shift;
    assign q_next    = {div_q[ACC_W-2:0], q_bit};

    // shared divider sequencing: load, ACC_W steps, store, four times
    always_ff @(posedge ap_clk) begin
        if (ap_rst || state != S_DIVIDE) begin
            div_idx  <= '0;
            div_cnt  <= '0;
            div_busy <= 1'b0;
            div_fin  <= 1'b0;
            div_rem  <= '0;
            div_q    <= '0;
        end else if (!div_fin) begin
            if (!div_busy) begin
                if (s0 == '0) begin
                    div_fin <= 1'b1;
                end else begin
                    div_q    <= num_sel;
                    div_rem  <= '0;
                    div_cnt  <= '0;
                    div_busy <= 1'b1;
                end
            end else begin
                div_rem <= rem_next;
                div_q   <= q_next;
                div_cnt <= div_cnt + 1'b1;
                if (div_cnt == CNT_LAST) begin
                    div_busy <= 1'b0;
                    div_idx  <= div_idx + 2'd1;
                    if (div_idx == 2'd3) div_fin <= 1'b1;
                end
            end
        end
    end

    // quotient store; an empty weight sum forces all quotients to zero
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int k = 0; k < 4; k++) quot[k] <= '0;
        end else if (state == S_DIVIDE && !div_fin && !div_busy && s0 == '0) begin
            for (int k = 0; k < 4; k++) quot[k] <= '0;
        end else if (state == S_DIVIDE && div_busy && div_cnt == CNT_LAST) begin
            quot[div_idx] <= q_next;
        end
    end

    // variance = E[x^2] - E[x]^2, clamped at zero
    always_comb begin
        mx_w  = {{ACC_W{1'b0}}, quot[0]};
        my_w  = {{ACC_W{1'b0}}, quot[1]};
        qx_w  = {{ACC_W{1'b0}}, quot[2]};
        qy_w  = {{ACC_W{1'b0}}, quot[3]};
        mx_sq = mx_w * mx_w;
        my_sq = my_w * my_w;
        vx    = (qx_w > mx_sq) ? (qx_w - mx_sq) : '0;
        vy    = (qy_w > my_sq) ? (qy_w - my_sq) : '0;
    end

    // result registers: all five load together, each clears after its handshake
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            res_valid <= '0;
            for (int k = 0; k < 5; k++) res_data[k] <= '0;
        end else if (state == S_DIVIDE && div_fin) begin
            res_data[0] <= pk;
            res_data[1] <= sat_pos(mx_w);
            res_data[2] <= sat_pos(my_w);
            res_data[3] <= sat_pos(vx);
            res_data[4] <= sat_pos(vy);
            res_valid   <= 5'b11111;
        end else begin
            res_valid <= res_valid & ~res_hs;
        end
    end

    assign layer15_out_V_data_0_V_TDATA  = res_data[0];
    assign layer15_out_V_data_1_V_TDATA  = res_data[1];
    assign layer15_out_V_data_2_V_TDATA  = res_data[2];
    assign layer15_out_V_data_3_V_TDATA  = res_data[3];
    assign layer15_out_V_data_4_V_TDATA  = res_data[4];
    assign layer15_out_V_data_0_V_TVALID = res_valid[0];
    assign layer15_out_V_data_1_V_TVALID = res_valid[1];
    assign layer15_out_V_data_2_V_TVALID = res_valid[2];
    assign layer15_out_V_data_3_V_TVALID = res_valid[3];
    assign layer15_out_V_data_4_V_TVALID = res_valid[4];

endmodule

// File: tb/tb_myproject_gauss_moments.sv
// Directed bench for the Gaussian-spot moment estimator.
module tb_myproject_gauss_moments;

    localparam int ROWS = 48;
    localparam int COLS = 48;
    localparam int NPIX = ROWS * COLS;
    localparam int MAX_LAT = 4 * (40 + 2);

    // clock / reset
    logic ap_clk;
    logic ap_rst;
    logic ap_start;
    logic ap_idle, ap_ready, ap_done;
    logic [15:0] in_data;
    logic in_valid, in_tready;
    logic [15:0] out_data [5];
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic [1:0]  dbg_state;
    logic v0, v1, v2, v3, v4;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    assign out_valid = {v4, v3, v2, v1, v0};

    myproject_gauss_moments dut (
        .ap_clk                         (ap_clk),
        .ap_rst                         (ap_rst),
        .ap_start                       (ap_start),
        .ap_idle                        (ap_idle),
        .ap_ready                       (ap_ready),
        .ap_done                        (ap_done),
        .conv2d_input_V_data_0_V_TDATA  (in_data),
        .conv2d_input_V_data_0_V_TVALID (in_valid),
        .conv2d_input_V_data_0_V_TREADY (in_tready),
        .layer15_out_V_data_0_V_TDATA   (out_data[0]),
        .layer15_out_V_data_0_V_TVALID  (v0),
        .layer15_out_V_data_0_V_TREADY  (out_ready[0]),
        .layer15_out_V_data_1_V_TDATA   (out_data[1]),
        .layer15_out_V_data_1_V_TVALID  (v1),
        .layer15_out_V_data_1_V_TREADY  (out_ready[1]),
        .layer15_out_V_data_2_V_TDATA   (out_data[2]),
        .layer15_out_V_data_2_V_TVALID  (v2),
        .layer15_out_V_data_2_V_TREADY  (out_ready[2]),
        .layer15_out_V_data_3_V_TDATA   (out_data[3]),
        .layer15_out_V_data_3_V_TVALID  (v3),
        .layer15_out_V_data_3_V_TREADY  (out_ready[3]),
        .layer15_out_V_data_4_V_TDATA   (out_data[4]),
        .layer15_out_V_data_4_V_TVALID  (v4),
        .layer15_out_V_data_4_V_TREADY  (out_ready[4]),
        .dbg_state                      (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // observations collected by run_frame
    logic [15:0] obs_data [5];
    int seen [5];
    int rdy_cnt, done_cnt, tmo, lat;
    logic all_valid_first;

    // pixel images
    function automatic logic [15:0] pix_val(input int mode, input int r, input int c);
        case (mode)
            0: return (r == 10 && c == 20) ? 16'd100 : 16'd0;
            1: return 16'd1;
            2: return 16'd0;
            3: return (r == 0 && c == 47) ? 16'd7 : 16'hFFFB;
            4: return 16'hFFFD;
            5: return (r == 0 && (c == 0 || c == 4)) ? 16'd10 : 16'd0;
            6: return (r == 2 && c == 5) ? 16'd3 : ((r == 6 && c == 5) ? 16'd1 : 16'd0);
            default: return 16'd0;
        endcase
    endfunction

    // hand-computed results {out4, out3, out2, out1, out0}
    function automatic logic [15:0] exp_val(input int mode, input int k);
        logic [79:0] row;
        case (mode)
            0: row = {16'd0,   16'd0,   16'd10, 16'd20, 16'd100};
            1: row = {16'd215, 16'd215, 16'd23, 16'd23, 16'd1};
            2: row = {16'd0,   16'd0,   16'd0,  16'd0,  16'd0};
            3: row = {16'd0,   16'd0,   16'd0,  16'd47, 16'd7};
            4: row = {16'd0,   16'd0,   16'd0,  16'd0,  16'hFFFD};
            5: row = {16'd0,   16'd4,   16'd0,  16'd2,  16'd10};
            6: row = {16'd3,   16'd0,   16'd3,  16'd5,  16'd3};
            default: row = '0;
        endcase
        return row[k*16 +: 16];
    endfunction

    // driver: starts a frame (caller is at a negedge), streams max_beats
    // pixels, and when the frame is complete collects the five result words
    task automatic run_frame(input int mode, input bit stall, input int max_beats);
        int idx;
        int cyc;
        bit any_seen;
        for (int k = 0; k < 5; k++) begin
            obs_data[k] = '0;
            seen[k] = 0;
        end
        rdy_cnt = 0; done_cnt = 0; tmo = 0; lat = -1;
        all_valid_first = 1'b0; any_seen = 1'b0;
        ap_start = 1'b1;
        in_valid = 1'b0;
        idx = 0; cyc = 0;
        while (idx < max_beats && cyc < 20000) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            if (ap_ready) rdy_cnt++;
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = pix_val(mode, idx / COLS, idx % COLS);
            if (in_valid && in_tready) idx++;
            cyc++;
        end
        if (idx < max_beats) tmo = 1;
        if (max_beats < NPIX || tmo != 0) begin
            @(negedge ap_clk);
            in_valid = 1'b0;
            return;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 1000) begin
            @(negedge ap_clk);
            cyc++;
            in_valid = 1'b0;
            if (ap_ready) rdy_cnt++;
            for (int k = 0; k < 5; k++) out_ready[k] = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
            #1;
            if (!any_seen && out_valid != 5'd0) begin
                any_seen = 1'b1;
                lat = cyc;
                all_valid_first = (out_valid == 5'b11111);
            end
            for (int k = 0; k < 5; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    obs_data[k] = out_data[k];
                    seen[k]++;
                end
            end
            if (ap_done) done_cnt++;
        end
        if (done_cnt == 0) tmo = 1;
        @(negedge ap_clk);
        out_ready = '0;
        if (ap_ready) rdy_cnt++;
        if (ap_done) done_cnt++;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset ap_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL reset ap_ready: got %b expected 0", ap_ready); end
        checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL reset ap_done: got %b expected 0", ap_done); end
        checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL reset tready: got %b expected 0", in_tready); end
        checks++; if (out_valid !== 5'd0) begin errors++; $display("FAIL reset tvalid: got %b expected 00000", out_valid); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_data[k] !== 16'd0) begin errors++; $display("FAIL reset out%0d tdata: got %h expected 0000", k, out_data[k]); end
        end
    endtask

    task automatic test_directed();
        int modes [6] = '{0, 1, 2, 3, 4, 5};
        for (int i = 0; i < 6; i++) begin
            run_frame(modes[i], 1'b0, NPIX);
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_data[k] !== exp_val(modes[i], k)) begin
                    errors++; $display("FAIL directed mode%0d out%0d: got %h expected %h", modes[i], k, obs_data[k], exp_val(modes[i], k));
                end
                checks++;
                if (seen[k] !== 1) begin errors++; $display("FAIL directed mode%0d out%0d words: got %0d expected 1", modes[i], k, seen[k]); end
            end
            checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL directed mode%0d ap_ready pulses: got %0d expected 1", modes[i], rdy_cnt); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL directed mode%0d ap_done pulses: got %0d expected 1", modes[i], done_cnt); end
            checks++; if (tmo !== 0) begin errors++; $display("FAIL directed mode%0d timeout: got %0d expected 0", modes[i], tmo); end
            checks++; if (all_valid_first !== 1'b1) begin errors++; $display("FAIL directed mode%0d tvalid together: got %b expected 1", modes[i], all_valid_first); end
            checks++; if (lat < 1 || lat > MAX_LAT) begin errors++; $display("FAIL directed mode%0d latency: got %0d expected 1..%0d", modes[i], lat, MAX_LAT); end
            checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL directed mode%0d idle after done: got %b expected 1", modes[i], ap_idle); end
        end
    endtask

    task automatic test_stall();
        int modes [2] = '{1, 6};
        for (int i = 0; i < 2; i++) begin
            run_frame(modes[i], 1'b1, NPIX);
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_data[k] !== exp_val(modes[i], k)) begin
                    errors++; $display("FAIL stall mode%0d out%0d: got %h expected %h", modes[i], k, obs_data[k], exp_val(modes[i], k));
                end
                checks++;
                if (seen[k] !== 1) begin errors++; $display("FAIL stall mode%0d out%0d words: got %0d expected 1", modes[i], k, seen[k]); end
            end
            checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL stall mode%0d ap_ready pulses: got %0d expected 1", modes[i], rdy_cnt); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall mode%0d ap_done pulses: got %0d expected 1", modes[i], done_cnt); end
            checks++; if (tmo !== 0) begin errors++; $display("FAIL stall mode%0d timeout: got %0d expected 0", modes[i], tmo); end
            checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL stall mode%0d idle after done: got %b expected 1", modes[i], ap_idle); end
        end
    endtask

    task automatic test_reset_midframe();
        run_frame(1, 1'b0, 1000);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL midreset ap_idle: got %b expected 1", ap_idle); end
        checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL midreset tready: got %b expected 0", in_tready); end
        checks++; if (out_valid !== 5'd0) begin errors++; $display("FAIL midreset tvalid: got %b expected 00000", out_valid); end
        checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL midreset ap_ready: got %b expected 0", ap_ready); end
        run_frame(0, 1'b0, NPIX);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_data[k] !== exp_val(0, k)) begin errors++; $display("FAIL midreset fresh out%0d: got %h expected %h", k, obs_data[k], exp_val(0, k)); end
            checks++;
            if (seen[k] !== 1) begin errors++; $display("FAIL midreset fresh out%0d words: got %0d expected 1", k, seen[k]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midreset fresh ap_done pulses: got %0d expected 1", done_cnt); end
        checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL midreset fresh ap_ready pulses: got %0d expected 1", rdy_cnt); end
    endtask

    // second frame starts in the cycle right after ap_done
    task automatic test_back_to_back();
        int modes [2] = '{6, 5};
        for (int i = 0; i < 2; i++) begin
            run_frame(modes[i], 1'b0, NPIX);
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs_data[k] !== exp_val(modes[i], k)) begin
                    errors++; $display("FAIL b2b mode%0d out%0d: got %h expected %h", modes[i], k, obs_data[k], exp_val(modes[i], k));
                end
            end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b mode%0d ap_done pulses: got %0d expected 1", modes[i], done_cnt); end
            checks++; if (tmo !== 0) begin errors++; $display("FAIL b2b mode%0d timeout: got %0d expected 0", modes[i], tmo); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
